// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// operation encoding, control states and small op-decode helpers.
package mips_muldiv_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_is_muldiv(input logic [OP_W-1:0] op);
    return op <= OP_DIVU;
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Iterative unsigned shift datapath: one bit per step of shift-add multiply
// or restoring shift-subtract divide on operand magnitudes.
module mips_muldiv_core
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_i,
  input  logic                      step_i,
  input  logic                      div_i,
  input  logic [DATA_WIDTH-1:0]     a_mag_i,
  input  logic [DATA_WIDTH-1:0]     b_mag_i,
  output logic [2*DATA_WIDTH-1:0]   prod_o,
  output logic [DATA_WIDTH-1:0]     quo_o,
  output logic [DATA_WIDTH-1:0]     rem_o
);

  localparam int unsigned W = DATA_WIDTH;

  // acc_q holds the product, or the quotient in its low half while dividing
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   opnd_q;
  logic           div_q;
  logic [W:0]     add_sum;
  logic [W+1:0]   shifted;
  logic [W+1:0]   trial;

  always_comb begin
    add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    shifted = {rem_q, acc_q[W-1]};
    trial   = shifted - {2'b00, opnd_q};
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (div_q) begin
      if (trial[W+1]) begin
        rem_d          = shifted[W:0];
        acc_d[W-1:0]   = {acc_q[W-2:0], 1'b0};
      end else begin
        rem_d          = trial[W:0];
        acc_d[W-1:0]   = {acc_q[W-2:0], 1'b1};
      end
    end else if (acc_q[0]) begin
      acc_d = {add_sum, acc_q[W-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      rem_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      div_q <= div_i;
      rem_q <= '0;
      if (div_i) begin
        acc_q  <= {W'(0), a_mag_i};
        opnd_q <= b_mag_i;
      end else begin
        acc_q  <= {W'(0), b_mag_i};
        opnd_q <= a_mag_i;
      end
    end else if (step_i) begin
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  assign prod_o = acc_q;
  assign quo_o  = acc_q[W-1:0];
  assign rem_o  = rem_q[W-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS multiply/divide unit: control FSM, iteration counter, sign tracking,
// architectural HI/LO registers and pipeline handshake around the shift core.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     hi_q, lo_q, a_q;
  logic             div_q, prod_neg_q, rem_neg_q, b_zero_q;
  logic             busy_q, done_q, dbz_q;

  logic             accept_c, load_c, step_c, sgn_c, div_op_c;
  logic [W-1:0]     a_mag_c, b_mag_c, quo_c, rem_c;
  logic [W-1:0]     hi_d, lo_d;
  logic [2*W-1:0]   prod_c, prod_fix_c;

  // Request decode; flush always suppresses acceptance
  always_comb begin
    accept_c = (state_q == IDLE) && start_i && !flush_i;
    load_c   = accept_c && op_is_muldiv(op_i);
    step_c   = (state_q == CALC) && !flush_i;
    sgn_c    = op_is_signed(op_i);
    div_op_c = op_is_div(op_i);
    a_mag_c  = (sgn_c && a_i[W-1]) ? -a_i : a_i;
    b_mag_c  = (sgn_c && b_i[W-1]) ? -b_i : b_i;
  end

  mips_muldiv_core #(
    .DATA_WIDTH(W)
  ) u_core (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_c),
    .step_i  (step_c),
    .div_i   (div_op_c),
    .a_mag_i (a_mag_c),
    .b_mag_i (b_mag_c),
    .prod_o  (prod_c),
    .quo_o   (quo_c),
    .rem_o   (rem_c)
  );

  // Sign-corrected result; a zero divisor bypasses the fix entirely
  always_comb begin
    prod_fix_c = prod_neg_q ? -prod_c : prod_c;
    hi_d       = prod_fix_c[2*W-1:W];
    lo_d       = prod_fix_c[W-1:0];
    if (div_q) begin
      if (b_zero_q) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = rem_neg_q  ? -rem_c : rem_c;
        lo_d = prod_neg_q ? -quo_c : quo_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      div_q      <= 1'b0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (load_c) begin
              state_q    <= CALC;
              busy_q     <= 1'b1;
              cnt_q      <= CNT_W'(W);
              a_q        <= a_i;
              div_q      <= div_op_c;
              prod_neg_q <= sgn_c & (a_i[W-1] ^ b_i[W-1]);
              rem_neg_q  <= sgn_c & a_i[W-1];
              b_zero_q   <= (b_i == '0);
              dbz_q      <= 1'b0;
            end else if (accept_c && (op_i == OP_MTHI)) begin
              hi_q  <= a_i;
              dbz_q <= 1'b0;
            end else if (accept_c && (op_i == OP_MTLO)) begin
              lo_q  <= a_i;
              dbz_q <= 1'b0;
            end
          end
          CALC: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            dbz_q   <= div_q & b_zero_q;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, corner
// sequences and random ops against an arithmetic reference model.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, dbz;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dbz8;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo),
    .div_by_zero_o(dbz)
  );

  mips_muldiv_unit #(.DATA_WIDTH(8)) dut8 (
    .clk_i(clk), .reset_i(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8),
    .div_by_zero_o(dbz8)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] sext(input logic [31:0] x, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    if (x[w-1]) return $signed((64'(x) & m) | ~m);
    return $signed(64'(x) & m);
  endfunction

  // Architectural result of one request at width w, from plain integer arithmetic
  function automatic res_t model(input int w, input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input res_t prev);
    res_t r;
    logic [63:0] m, ux, uy, up;
    logic signed [63:0] sx, sy, sp;
    r  = prev;
    m  = (64'd1 << w) - 64'd1;
    ux = 64'(x) & m;
    uy = 64'(y) & m;
    sx = sext(x, w);
    sy = sext(y, w);
    if (o <= 3'd5) r.dbz = 1'b0;
    case (o)
      3'd0: begin sp = sx * sy; up = 64'(sp); r.hi = 32'((up >> w) & m); r.lo = 32'(up & m); end
      3'd1: begin up = ux * uy; r.hi = 32'((up >> w) & m); r.lo = 32'(up & m); end
      3'd2, 3'd3: begin
        if (uy == 64'd0) begin
          r.lo = 32'(m); r.hi = 32'(ux); r.dbz = 1'b1;
        end else if (o == 3'd2) begin
          sp = sx / sy; r.lo = 32'(64'(sp) & m);
          sp = sx % sy; r.hi = 32'(64'(sp) & m);
        end else begin
          r.lo = 32'(ux / uy); r.hi = 32'(ux % uy);
        end
      end
      3'd4: r.hi = 32'(ux);
      3'd5: r.lo = 32'(ux);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Drive one request; returns at the sample point of cycle 1
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0;
  endtask

  // Wait for done from cycle c0; cyc is the done cycle (0 on timeout)
  task automatic wait_done(input int c0, output int cyc, output int nbusy);
    cyc = c0; nbusy = 0;
    while (!done && cyc < 200) begin
      if (busy) nbusy++;
      @(negedge clk); cyc++;
    end
    if (!done) cyc = 0;
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int cyc);
    @(negedge clk); start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk); start8 = 1'b0; cyc = 1;
    while (!done8 && cyc < 100) begin @(negedge clk); cyc++; end
    if (!done8) cyc = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs [10];
  int          cyc, nb, ndone, fc;
  res_t        mr, ex;
  logic [2:0]  ro;
  logic [31:0] rx, ry;

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000, 1'b0};
    vecs[4] = '{3'd3, 32'd9,         32'd0,          32'd9,         32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h1,         1'b0};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0,         1'b0};
    vecs[8] = '{3'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h8000_0001, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dbz", dbz, 0);
    chk("rst_hi", hi, 0);     chk("rst_lo", lo, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, cyc, nb);
      chk($sformatf("v%0d_lat", i), cyc, LAT);
      chk($sformatf("v%0d_busycnt", i), nb, LAT - 1);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
    end

    // div_by_zero clears on the next accepted start
    issue(3'd3, 32'd9, 32'd0);
    wait_done(1, cyc, nb);
    chk("dbz_set", dbz, 1);
    issue(3'd0, 32'd2, 32'd3);
    chk("dbz_cleared", dbz, 0);
    wait_done(1, cyc, nb);
    chk("dbz_next_lo", lo, 6);

    // start while busy is ignored
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1; b = 32'd1;
    @(negedge clk); start = 1'b0;
    wait_done(11, cyc, nb);
    chk("busy_start_lat", cyc, LAT);
    chk("busy_start_hi", hi, 32'hFFFF_FFFE);
    chk("busy_start_lo", lo, 32'h1);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("busy_start_single_done", ndone, 0);

    // MTHI / MTLO then a flushed MULT
    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", hi, 32'h1234); chk("mthi_busy", busy, 0); chk("mthi_done", done, 0);
    issue(3'd5, 32'h5678, 32'd0);
    chk("mtlo_lo", lo, 32'h5678); chk("mtlo_busy", busy, 0);
    issue(3'd0, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", busy, 0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("flush_no_done", ndone, 0);
    chk("flush_hi", hi, 32'h1234); chk("flush_lo", lo, 32'h5678);

    // flush beats start in the same cycle
    @(negedge clk); flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD;
    @(negedge clk); op = 3'd0;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    chk("flush_start_hi", hi, 32'h1234); chk("flush_start_busy", busy, 0);

    // back-to-back: start in the done cycle is accepted
    issue(3'd3, 32'd100, 32'd7);
    wait_done(1, cyc, nb);
    chk("b2b_first_lo", lo, 14);
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    @(negedge clk); start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done(1, cyc, nb);
    chk("b2b_lat", cyc, LAT); chk("b2b_lo", lo, 42); chk("b2b_hi", hi, 0);

    // reset in the middle of a divide
    issue(3'd2, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_dbz", dbz, 0);
    chk("midrst_hi", hi, 0);     chk("midrst_lo", lo, 0);

    // random requests against the reference model
    mr = '0;
    for (int k = 0; k < 150; k++) begin
      ro = 3'($urandom_range(0, 7));
      rx = pick();
      ry = pick();
      ex = model(32, ro, rx, ry, mr);
      issue(ro, rx, ry);
      if (ro <= 3'd3) begin
        if ($urandom_range(0, 7) == 0) begin
          fc = $urandom_range(1, W + 1);
          repeat (fc - 1) @(negedge clk);
          flush = 1'b1;
          @(negedge clk); flush = 1'b0;
          mr.dbz = 1'b0;
          chk($sformatf("r%0d_flush_busy", k), busy, 0);
          ndone = 0;
          repeat (W + 4) begin @(negedge clk); if (done) ndone++; end
          chk($sformatf("r%0d_flush_done", k), ndone, 0);
          chk($sformatf("r%0d_flush_hilo", k), {hi, lo}, {mr.hi, mr.lo});
          chk($sformatf("r%0d_flush_dbz", k), dbz, mr.dbz);
        end else begin
          wait_done(1, cyc, nb);
          chk($sformatf("r%0d_lat", k), cyc, LAT);
          chk($sformatf("r%0d_hi op=%0d a=%h b=%h", k, ro, rx, ry), hi, ex.hi);
          chk($sformatf("r%0d_lo op=%0d a=%h b=%h", k, ro, rx, ry), lo, ex.lo);
          chk($sformatf("r%0d_dbz", k), dbz, ex.dbz);
          mr = ex;
        end
      end else begin
        chk($sformatf("r%0d_mt_busy", k), busy, 0);
        chk($sformatf("r%0d_mt_done", k), done, 0);
        chk($sformatf("r%0d_mt_hilo", k), {hi, lo}, {ex.hi, ex.lo});
        chk($sformatf("r%0d_mt_dbz", k), dbz, ex.dbz);
        mr = ex;
      end
    end

    // narrow-width instance
    run8(3'd0, 8'h80, 8'h80, cyc);
    chk("w8_lat", cyc, 10); chk("w8_hi", hi8, 8'h40); chk("w8_lo", lo8, 8'h00);
    mr = '0;
    mr.hi = 32'h40;
    for (int k = 0; k < 30; k++) begin
      ro = 3'($urandom_range(0, 3));
      rx = 32'(8'($urandom()));
      ry = 32'(8'($urandom_range(0, 3) == 0 ? 0 : $urandom()));
      ex = model(8, ro, rx, ry, mr);
      run8(ro, rx[7:0], ry[7:0], cyc);
      chk($sformatf("w8r%0d_lat", k), cyc, 10);
      chk($sformatf("w8r%0d_hi op=%0d a=%h b=%h", k, ro, rx[7:0], ry[7:0]), hi8, ex.hi);
      chk($sformatf("w8r%0d_lo op=%0d a=%h b=%h", k, ro, rx[7:0], ry[7:0]), lo8, ex.lo);
      chk($sformatf("w8r%0d_dbz", k), dbz8, ex.dbz);
      mr = ex;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
